// File: rtl/fir_pkg.sv
// Shared constants, FSM encoding and the default coefficient table for fir_tap_server.
package fir_pkg;

  localparam int NTAPS    = 71;
  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 7;
  localparam int TIMEOUT  = 255;
  localparam int WDOG_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_GAP
  } state_t;

  typedef logic [NTAPS-1:0][15:0] coef_mag_t;
  typedef logic [NTAPS-1:0]       coef_sign_t;

  // Symmetric taper around the centre tap; a few taps negative.
  function automatic coef_mag_t coef_mag_init();
    coef_mag_t t;
    for (int k = 0; k < NTAPS; k++) begin
      int d;
      d = (k <= NTAPS / 2) ? k : NTAPS - 1 - k;
      t[k] = 16'(32 + d * d * 8);
    end
    return t;
  endfunction

  function automatic coef_sign_t coef_sign_init();
    coef_sign_t t;
    for (int k = 0; k < NTAPS; k++) t[k] = ((k % 5) == 4);
    return t;
  endfunction

  localparam coef_mag_t  COEF_MAG  = coef_mag_init();
  localparam coef_sign_t COEF_SIGN = coef_sign_init();

endpackage

// File: rtl/fir_coef_table.sv
// Coefficient lookup by tap address: constant ROM by default, or a
// reset-initialised loadable register file when FIR_COEF_LOAD_EN is defined.
module fir_coef_table
  import fir_pkg::*;
(
`ifdef FIR_COEF_LOAD_EN
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_mag,
  input  logic              wr_sign,
`endif
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_mag,
  output logic              rd_sign
);

  coef_mag_t  mag_q;
  coef_sign_t sign_q;
  logic       rd_ok;

`ifdef FIR_COEF_LOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q  <= COEF_MAG;
      sign_q <= COEF_SIGN;
    end else if (wr_en && (wr_addr < ADDR_W'(NTAPS))) begin
      mag_q[wr_addr]  <= wr_mag;
      sign_q[wr_addr] <= wr_sign;
    end
  end
`else
  assign mag_q  = COEF_MAG;
  assign sign_q = COEF_SIGN;
`endif

  assign rd_ok   = (rd_addr < ADDR_W'(NTAPS));
  assign rd_mag  = rd_ok ? mag_q[rd_addr]  : 16'd0;
  assign rd_sign = rd_ok ? sign_q[rd_addr] : 1'b0;

endmodule

// File: rtl/fir_tap_server.sv
// MAC tap-fetch responder: sample history, coefficient lookup, pass sequencing
// and result capture. FIR_COEF_LOAD_EN adds runtime coefficient writes.
module fir_tap_server
  import fir_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                mac_enable,
  input  logic [ADDR_W-1:0]   mac_address,
  output logic [31:0]         mac_x,
  output logic [15:0]         mac_h,
  output logic                mac_sign,
  input  logic [31:0]         mac_y,
  input  logic                mac_over,
`ifdef FIR_COEF_LOAD_EN
  input  logic                coef_we,
  input  logic [ADDR_W-1:0]   coef_addr,
  input  logic [15:0]         coef_mag,
  input  logic                coef_sign,
`endif
  output logic [31:0]         y_out,
  output logic                y_valid,
  output logic                timeout_err
);

  state_t                         state, state_nx;
  logic [SAMPLE_W-1:0]            sample_q;
  logic [NTAPS-1:0][SAMPLE_W-1:0] hist;
  logic [WDOG_W-1:0]              wdog;
  logic                           wdog_exp;
  logic                           addr_ok;

  // Last permitted RUN cycle; mac_over in this cycle still wins.
  assign wdog_exp = (wdog == WDOG_W'(TIMEOUT - 1));

  // GAP doubles as the reset state so IDLE is reached one clk after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_GAP;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    sample_ready = 1'b0;
    mac_enable   = 1'b0;
    case (state)
      S_IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) state_nx = S_LOAD;
      end
      S_LOAD: state_nx = S_RUN;
      S_RUN: begin
        mac_enable = 1'b1;
        if (mac_over)      state_nx = S_CAPTURE;
        else if (wdog_exp) state_nx = S_GAP;
      end
      S_CAPTURE: begin
        mac_enable = 1'b1;
        state_nx   = S_GAP;
      end
      S_GAP:   state_nx = S_IDLE;
      default: state_nx = S_GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= '0;
      hist        <= '0;
      wdog        <= '0;
      y_out       <= '0;
      y_valid     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (state == S_IDLE && sample_valid) sample_q <= sample_in;
      if (state == S_LOAD) begin
        hist <= {hist[NTAPS-2:0], sample_q};
        wdog <= '0;
      end
      if (state == S_RUN) begin
        wdog <= wdog + 1'b1;
        if (!mac_over && wdog_exp) timeout_err <= 1'b1;
      end
      if (state == S_CAPTURE) begin
        y_out   <= mac_y;
        y_valid <= 1'b1;
      end
    end
  end

  assign addr_ok = (mac_address < ADDR_W'(NTAPS));
  assign mac_x   = addr_ok ? 32'(hist[mac_address]) : 32'd0;

  fir_coef_table u_coef (
`ifdef FIR_COEF_LOAD_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (coef_we && (state == S_IDLE)),
    .wr_addr (coef_addr),
    .wr_mag  (coef_mag),
    .wr_sign (coef_sign),
`endif
    .rd_addr (mac_address),
    .rd_mag  (mac_h),
    .rd_sign (mac_sign)
  );

endmodule

// File: tb/tb_fir_tap_server.sv
// Directed bench for fir_tap_server with a simple MAC model and a result scoreboard.
module tb_fir_tap_server;
  import fir_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic                mac_enable;
  logic [ADDR_W-1:0]   mac_address;
  logic [31:0]         mac_x;
  logic [15:0]         mac_h;
  logic                mac_sign;
  logic [31:0]         mac_y;
  logic                mac_over;
`ifdef FIR_COEF_LOAD_EN
  logic                coef_we;
  logic [ADDR_W-1:0]   coef_addr;
  logic [15:0]         coef_mag;
  logic                coef_sign;
`endif
  logic [31:0]         y_out;
  logic                y_valid;
  logic                timeout_err;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] sb_q[$];

  fir_tap_server dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mac_enable   (mac_enable),
    .mac_address  (mac_address),
    .mac_x        (mac_x),
    .mac_h        (mac_h),
    .mac_sign     (mac_sign),
    .mac_y        (mac_y),
    .mac_over     (mac_over),
`ifdef FIR_COEF_LOAD_EN
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_mag     (coef_mag),
    .coef_sign    (coef_sign),
`endif
    .y_out        (y_out),
    .y_valid      (y_valid),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result scoreboard: every y_valid must match the oldest pending MAC result.
  always @(negedge clk) begin
    if (rst_n && y_valid) begin
      if (sb_q.size() == 0) chk("y_unexpected", {31'd0, y_valid}, 32'd0);
      else                  chk("y_out", y_out, sb_q.pop_front());
    end
  end

  // Waits for IDLE, hands over one sample, returns on the first RUN cycle.
  task automatic start_sample(input logic [15:0] s);
    int w;
    w = 0;
    while (!sample_ready && w < 400) begin
      tick();
      w++;
    end
    chk("ready_wait", {31'd0, sample_ready}, 32'd1);
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("load_enable", {31'd0, mac_enable}, 32'd0);
    chk("load_ready", {31'd0, sample_ready}, 32'd0);
    tick();
    chk("run_enable", {31'd0, mac_enable}, 32'd1);
  endtask

  // MAC model: after 'extra' further RUN cycles, pulse mac_over with result y.
  task automatic finish_pass(input logic [31:0] y, input int extra);
    repeat (extra) tick();
    mac_y    = y;
    mac_over = 1'b1;
    sb_q.push_back(y);
    tick();
    mac_over = 1'b0;
    chk("cap_enable", {31'd0, mac_enable}, 32'd1);
    chk("cap_ready", {31'd0, sample_ready}, 32'd0);
    chk("cap_yvalid", {31'd0, y_valid}, 32'd0);
    tick();
    chk("gap_enable", {31'd0, mac_enable}, 32'd0);
    chk("gap_ready", {31'd0, sample_ready}, 32'd0);
    chk("gap_yvalid", {31'd0, y_valid}, 32'd1);
    chk("gap_yout", y_out, y);
    tick();
    chk("idle_ready", {31'd0, sample_ready}, 32'd1);
    chk("idle_yvalid", {31'd0, y_valid}, 32'd0);
  endtask

  task automatic probe_x(input string tag, input int a, input logic [31:0] expv);
    mac_address = ADDR_W'(a);
    #1;
    chk(tag, mac_x, expv);
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    mac_address  = '0;
    mac_y        = '0;
    mac_over     = 1'b0;
`ifdef FIR_COEF_LOAD_EN
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_mag  = '0;
    coef_sign = 1'b0;
`endif

    // Test 1: reset state and empty history
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, sample_ready}, 32'd0);
    chk("rst_enable", {31'd0, mac_enable}, 32'd0);
    chk("rst_yvalid", {31'd0, y_valid}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rel_ready", {31'd0, sample_ready}, 32'd1);
    chk("rel_enable", {31'd0, mac_enable}, 32'd0);
    chk("rel_yout", y_out, 32'd0);
    for (int a = 0; a < NTAPS; a++) probe_x("rst_hist", a, 32'd0);
    mac_address = 7'd100;
    #1;
    chk("oob_x", mac_x, 32'd0);
    chk("oob_h", {16'd0, mac_h}, 32'd0);
    chk("oob_sign", {31'd0, mac_sign}, 32'd0);
    for (int a = 0; a < 3; a++) begin
      mac_address = ADDR_W'(a);
      #1;
      chk("coef_h", {16'd0, mac_h}, {16'd0, COEF_MAG[a]});
      chk("coef_sign", {31'd0, mac_sign}, {31'd0, COEF_SIGN[a]});
    end
    mac_address = 7'd70;
    #1;
    chk("coef_h_last", {16'd0, mac_h}, {16'd0, COEF_MAG[70]});

    // Test 2: history shift
    start_sample(16'd1);
    finish_pass(32'h0000_0011, NTAPS + 1);
    start_sample(16'd2);
    finish_pass(32'h0000_0022, NTAPS + 1);
    start_sample(16'd3);
    probe_x("hist0", 0, 32'd3);
    probe_x("hist1", 1, 32'd2);
    probe_x("hist2", 2, 32'd1);
    probe_x("hist3", 3, 32'd0);

    // Test 3: capture, enable low gap and ready return
    finish_pass(32'h0000_1234, NTAPS + 1);
    chk("y_hold", y_out, 32'h0000_1234);

    // Test 4: backpressure while in RUN
    start_sample(16'h0101);
    sample_in    = 16'hABCD;
    sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_ready", {31'd0, sample_ready}, 32'd0);
    end
    probe_x("bp_frozen", 0, 32'h0000_0101);
    finish_pass(32'h8000_0001, NTAPS - 3);
    start_sample(16'hABCD);
    probe_x("bp_hist0", 0, 32'h0000_ABCD);
    probe_x("bp_hist1", 1, 32'h0000_0101);
    probe_x("bp_hist2", 2, 32'd3);
    finish_pass(32'hFFFF_FFFE, NTAPS + 1);

    // Test 5: watchdog expiry, then mac_over on the last allowed cycle
    start_sample(16'h0007);
    repeat (TIMEOUT - 2) tick();
    chk("wd_254_err", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("wd_255_enable", {31'd0, mac_enable}, 32'd1);
    chk("wd_255_err", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("wd_err", {31'd0, timeout_err}, 32'd1);
    chk("wd_gap_enable", {31'd0, mac_enable}, 32'd0);
    chk("wd_yvalid", {31'd0, y_valid}, 32'd0);
    tick();
    chk("wd_idle", {31'd0, sample_ready}, 32'd1);
    start_sample(16'h0008);
    finish_pass(32'hDEAD_BEEF, TIMEOUT - 1);
    chk("wd_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset in the middle of a pass
    start_sample(16'h0055);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_enable", {31'd0, mac_enable}, 32'd0);
    chk("mrst_err", {31'd0, timeout_err}, 32'd0);
    chk("mrst_yout", y_out, 32'd0);
    probe_x("mrst_hist0", 0, 32'd0);
    probe_x("mrst_hist1", 1, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("mrst_ready", {31'd0, sample_ready}, 32'd1);

`ifdef FIR_COEF_LOAD_EN
    // Test 6: coefficient write in IDLE takes effect, write in RUN is ignored
    coef_we   = 1'b1;
    coef_addr = 7'd5;
    coef_mag  = 16'h0100;
    coef_sign = 1'b1;
    tick();
    coef_we     = 1'b0;
    mac_address = 7'd5;
    #1;
    chk("cw_h", {16'd0, mac_h}, 32'h0000_0100);
    chk("cw_sign", {31'd0, mac_sign}, 32'd1);
    start_sample(16'h0009);
    coef_we   = 1'b1;
    coef_addr = 7'd6;
    coef_mag  = 16'h0200;
    coef_sign = ~COEF_SIGN[6];
    tick();
    coef_we     = 1'b0;
    mac_address = 7'd6;
    #1;
    chk("cw_run_h", {16'd0, mac_h}, {16'd0, COEF_MAG[6]});
    chk("cw_run_sign", {31'd0, mac_sign}, {31'd0, COEF_SIGN[6]});
    finish_pass(32'h0000_5A5A, NTAPS);
`endif

    repeat (2) tick();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
